// File: rtl/pdec_pkg.sv
// pdec_pkg: shared types and the 2-to-4 decode function for the sequential decoder
package pdec_pkg;
  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;
  typedef enum logic {IDLE, DRIVE} state_t;
  localparam int FIFO_DEPTH = 2;
  function automatic onehot_t decode2to4(code_t c);
    return onehot_t'(4'b0001 << c);
  endfunction
endpackage

// File: rtl/p_decoder2to4_seq_if.sv
// p_decoder2to4_seq_if: code input handshake plus decoded output bundle
interface p_decoder2to4_seq_if;
  import pdec_pkg::*;
  code_t   A;
  logic    in_valid;
  logic    in_ready;
  onehot_t Y;
  logic    y_valid;
  logic    busy;
  modport master (output A, in_valid, input in_ready, Y, y_valid, busy);
  modport slave (input A, in_valid, output in_ready, Y, y_valid, busy);
endinterface

// File: rtl/code_fifo2.sv
// code_fifo2: 2-entry synchronous FIFO of 2-bit codes, overflow/underflow guarded
module code_fifo2 import pdec_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  code_t      din,
  input  logic       pop,
  output code_t      dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);
  code_t      mem_q [FIFO_DEPTH];
  logic       wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q ^ do_push;
    rd_d    = rd_q ^ do_pop;
    cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_q] <= din;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/p_decoder2to4_seq.sv
// p_decoder2to4_seq: buffers 2-bit codes and drives each as a one-hot word for HOLD cycles
module p_decoder2to4_seq import pdec_pkg::*; #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input logic clk,
  input logic rst,
  p_decoder2to4_seq_if.slave io
);
  state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  onehot_t    y_q, y_d;
  logic       yv_q, yv_d;
  logic       busy_q, busy_d;
  logic       push, pop, load;
  code_t      head;
  logic [1:0] count, count_nxt;
  logic       full, empty;
  // A full FIFO refuses a push even when the FSM pops the same cycle
  assign io.in_ready = !rst && !full;
  assign push = io.in_valid && io.in_ready;
  code_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (io.A),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    load      = !empty && (state_q == IDLE || cnt_q == '0);
    pop       = load;
    state_d   = load ? DRIVE : (state_q == DRIVE && cnt_q == '0) ? IDLE : state_q;
    cnt_d     = load ? CW'(HOLD - 1) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    y_d       = load ? decode2to4(head) : (state_d == IDLE) ? 4'b0000 : y_q;
    yv_d      = state_d == DRIVE;
    count_nxt = count + {1'b0, push} - {1'b0, pop};
    busy_d    = state_d == DRIVE || count_nxt != 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= 4'b0000;
      yv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      busy_q  <= busy_d;
    end
  end
  assign io.Y       = y_q;
  assign io.y_valid = yv_q;
  assign io.busy    = busy_q;
endmodule

// File: tb/tb_p_decoder2to4_seq.sv
// tb_p_decoder2to4_seq: scoreboard bench for HOLD=4 and HOLD=1 decoder instances
module tb_p_decoder2to4_seq;
  import pdec_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  p_decoder2to4_seq_if if4 ();
  p_decoder2to4_seq_if if1 ();
  p_decoder2to4_seq #(.HOLD(4), .CW(8)) u_dut4 (.clk(clk), .rst(rst), .io(if4));
  p_decoder2to4_seq #(.HOLD(1), .CW(8)) u_dut1 (.clk(clk), .rst(rst), .io(if1));
  onehot_t q4 [$];
  onehot_t q1 [$];
  int n_cmp = 0, n_bad = 0;
  int run4 = 0, last4 = 0, run1 = 0, last1 = 0;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic code_t prienc(logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return code_t'(i);
    return 2'd0;
  endfunction
  // Monitors: pop one expected word per valid cycle, track contiguous valid runs
  always @(negedge clk) begin
    if (if4.y_valid) begin
      if (q4.size() == 0) chk("dut4_spurious_valid", int'(if4.y_valid), 0);
      else chk("dut4_y", int'(if4.Y), int'(q4.pop_front()));
      run4++;
    end else begin
      if (run4 != 0) last4 = run4;
      run4 = 0;
      if (if4.Y != 4'b0000) chk("dut4_idle_y", int'(if4.Y), 0);
    end
  end
  always @(negedge clk) begin
    if (if1.y_valid) begin
      if (q1.size() == 0) chk("dut1_spurious_valid", int'(if1.y_valid), 0);
      else chk("dut1_y", int'(if1.Y), int'(q1.pop_front()));
      run1++;
    end else begin
      if (run1 != 0) last1 = run1;
      run1 = 0;
      if (if1.Y != 4'b0000) chk("dut1_idle_y", int'(if1.Y), 0);
    end
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit s, input code_t a, input onehot_t y_exp, output int stalls);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    stalls = 0;
    if (s) begin if1.A = a; if1.in_valid = 1'b1; end
    else begin if4.A = a; if4.in_valid = 1'b1; end
    do begin
      @(negedge clk);
      ok = s ? if1.in_ready : if4.in_ready;
      sync();
      if (!ok) stalls++;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) chk("send_timeout", 0, 1);
    else if (s) q1.push_back(y_exp);
    else repeat (4) q4.push_back(y_exp);
  endtask
  task automatic idle_all();
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int st;
    logic [3:0] rt_in  [4];
    onehot_t    rt_exp [4];
    int         s_exp  [4];
    code_t      b2b_a  [4];
    onehot_t    b2b_y  [4];
    rt_in  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    rt_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    b2b_a  = '{2'd0, 2'd1, 2'd3, 2'd2};
    b2b_y  = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    s_exp  = '{0, 0, 0, 3};
    rst = 1'b1;
    if4.A = 2'd0; if4.in_valid = 1'b0;
    if1.A = 2'd0; if1.in_valid = 1'b0;
    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready4", int'(if4.in_ready), 0);
    chk("rst_in_ready1", int'(if1.in_ready), 0);
    chk("rst_y", int'(if4.Y), 0);
    chk("rst_y_valid", int'(if4.y_valid), 0);
    chk("rst_busy", int'(if4.busy), 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready4", int'(if4.in_ready), 1);
    chk("post_rst_in_ready1", int'(if1.in_ready), 1);
    chk("post_rst_busy", int'(if4.busy), 0);
    // Single decode with latency and hold length
    sync();
    send(1'b0, 2'd2, 4'b0100, st);
    idle_all();
    chk("single_stalls", st, 0);
    @(negedge clk);
    chk("single_latency_pre", int'(if4.y_valid), 0);
    chk("single_busy", int'(if4.busy), 1);
    @(negedge clk);
    chk("single_first_valid", int'(if4.y_valid), 1);
    chk("single_first_y", int'(if4.Y), 4'b0100);
    repeat (3) @(negedge clk);
    chk("single_last_valid", int'(if4.y_valid), 1);
    @(negedge clk);
    chk("single_end_valid", int'(if4.y_valid), 0);
    chk("single_end_y", int'(if4.Y), 0);
    repeat (3) sync();
    chk("single_run", last4, 4);
    chk("single_drained", q4.size(), 0);
    chk("single_busy_end", int'(if4.busy), 0);
    // Back-to-back fill: fourth code waits until the first pop frees a slot
    for (int i = 0; i < 4; i++) begin
      send(1'b0, b2b_a[i], b2b_y[i], st);
      chk("b2b_stalls", st, s_exp[i]);
    end
    idle_all();
    repeat (20) sync();
    chk("b2b_run", last4, 16);
    chk("b2b_drained", q4.size(), 0);
    // Streaming with HOLD=1
    sync();
    send(1'b1, 2'd3, 4'b1000, st); chk("stream_stalls", st, 0);
    send(1'b1, 2'd2, 4'b0100, st); chk("stream_stalls", st, 0);
    send(1'b1, 2'd1, 4'b0010, st); chk("stream_stalls", st, 0);
    send(1'b1, 2'd0, 4'b0001, st); chk("stream_stalls", st, 0);
    idle_all();
    repeat (5) sync();
    chk("stream_run", last1, 4);
    chk("stream_drained", q1.size(), 0);
    // Reset during the second hold cycle of the first of two queued words
    send(1'b0, 2'd1, 4'b0010, st);
    send(1'b0, 2'd2, 4'b0100, st);
    idle_all();
    sync();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(if4.in_ready), 0);
    sync();
    chk("midrst_y", int'(if4.Y), 0);
    chk("midrst_y_valid", int'(if4.y_valid), 0);
    chk("midrst_busy", int'(if4.busy), 0);
    q4.delete();
    rst = 1'b0;
    repeat (10) sync();
    chk("midrst_run", last4, 2);
    chk("midrst_busy_after", int'(if4.busy), 0);
    // Round trip from priority-encoder codes
    for (int i = 0; i < 4; i++) send(1'b1, prienc(rt_in[i]), rt_exp[i], st);
    idle_all();
    repeat (5) sync();
    chk("roundtrip_run", last1, 4);
    chk("roundtrip_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
